// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state and owner encodings for the memory bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and memory-side signal bundle for the arbiter
interface mem_bus_arbiter_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [AWIDTH-1:0] cpu_addr;
  logic [DWIDTH-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_ack;
  logic [DWIDTH-1:0] cpu_rdata;
  logic              cpu_hold;

  logic              dma_req;
  logic              dma_we;
  logic [AWIDTH-1:0] dma_addr;
  logic [DWIDTH-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_ack;
  logic [DWIDTH-1:0] dma_rdata;
  logic              dma_hold;

  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_ack, cpu_rdata, cpu_hold,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_ack, dma_rdata, dma_hold,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_ack, cpu_rdata, cpu_hold,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_ack, dma_rdata, dma_hold,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_burst_counter.sv
// rtl/mem_bus_arbiter_burst_counter.sv - consecutive-grant counter, load-one or saturating increment
module arb_burst_counter #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_one_i,
  input  logic incr_i,
  output logic at_max_o
);
  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_one_i) begin
      cnt_d = CW'(1);
    end else if (incr_i && (cnt_q != CW'(MAX_BURST))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CW'(MAX_BURST));

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester single-port memory arbiter with burst-limited fairness
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AWIDTH    = 5,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_arbiter_if.slave bus
);
  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              cmd_we_q, cmd_we_d;
  logic [AWIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DWIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              load_one, incr, at_max;
  logic              own_req, oth_req;
  logic              in_issue, in_ack, busy;
  logic              cpu_gnt, dma_gnt, cpu_ack, dma_ack;

  assign own_req = (owner_q == OWN_CPU) ? bus.cpu_req : bus.dma_req;
  assign oth_req = (owner_q == OWN_CPU) ? bus.dma_req : bus.cpu_req;

  // The last owner keeps the bus until it has used its burst while the other side waits.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    load_one    = 1'b0;
    incr        = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (own_req && (!oth_req || !at_max)) begin
          incr    = 1'b1;
          state_d = ST_ISSUE;
        end else if (oth_req) begin
          owner_d  = other_owner(owner_q);
          load_one = 1'b1;
          state_d  = ST_ISSUE;
        end
        if (state_d == ST_ISSUE) begin
          if (owner_d == OWN_CPU) begin
            cmd_we_d    = bus.cpu_we;
            cmd_addr_d  = bus.cpu_addr;
            cmd_wdata_d = bus.cpu_wdata;
          end else begin
            cmd_we_d    = bus.dma_we;
            cmd_addr_d  = bus.dma_addr;
            cmd_wdata_d = bus.dma_wdata;
          end
        end
      end
      ST_ISSUE: state_d = ST_ACK;
      default:  state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ARB;
      owner_q     <= OWN_CPU;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  arb_burst_counter #(.MAX_BURST(MAX_BURST)) u_burst_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_one_i (load_one),
    .incr_i     (incr),
    .at_max_o   (at_max)
  );

  assign in_issue = (state_q == ST_ISSUE);
  assign in_ack   = (state_q == ST_ACK);
  assign busy     = in_issue | in_ack;
  assign cpu_gnt  = busy   & (owner_q == OWN_CPU);
  assign dma_gnt  = busy   & (owner_q == OWN_DMA);
  assign cpu_ack  = in_ack & (owner_q == OWN_CPU);
  assign dma_ack  = in_ack & (owner_q == OWN_DMA);

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.dma_ack   = dma_ack;
  assign bus.cpu_rdata = (cpu_ack && !cmd_we_q) ? bus.mem_rdata : '0;
  assign bus.dma_rdata = (dma_ack && !cmd_we_q) ? bus.mem_rdata : '0;
  // Gated by reset so every output reads 0 while reset is held.
  assign bus.cpu_hold  = rst & bus.cpu_req & ~cpu_gnt;
  assign bus.dma_hold  = rst & bus.dma_req & ~dma_gnt;

  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;
  assign bus.mem_re    = in_issue & ~cmd_we_q;
  assign bus.mem_we    = in_issue &  cmd_we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and random checks of two arbiter instances against a transfer-level model
module tb_mem_bus_arbiter;
  logic clk;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  mem_bus_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) if0 ();
  mem_bus_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) if1 ();

  mem_bus_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_BURST(4)) u_dut0 (.clk(clk), .rst(rst_n), .bus(if0));
  mem_bus_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_BURST(1)) u_dut1 (.clk(clk), .rst(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories behind each arbiter: synchronous read, plus a preload port used under reset.
  logic [7:0] pmem0 [32];
  logic [7:0] pmem1 [32];
  logic [7:0] rd0, rd1;
  logic       init_en;
  logic [4:0] init_addr;
  logic [7:0] init_data;

  always @(posedge clk) begin
    if (init_en) begin
      pmem0[init_addr] <= init_data;
      pmem1[init_addr] <= init_data;
    end
    if (if0.mem_we) pmem0[if0.mem_addr] <= if0.mem_wdata;
    if (if0.mem_re) rd0 <= pmem0[if0.mem_addr];
    if (if1.mem_we) pmem1[if1.mem_addr] <= if1.mem_wdata;
    if (if1.mem_re) rd1 <= pmem1[if1.mem_addr];
  end
  assign if0.mem_rdata = rd0;
  assign if1.mem_rdata = rd1;

  // Transfer-level model: phase 0 idle, 1 issue, 2 ack; side 0 = CPU, 1 = DMA.
  int  m_phase [2];
  int  m_owner [2];
  int  m_cnt   [2];
  int  m_we    [2];
  int  m_addr  [2];
  int  m_wdata [2];
  int  m_mem   [2][32];
  bit  m_last_ack [2][2];

  bit         q_req   [2][2];
  bit         q_we    [2][2];
  logic [4:0] q_addr  [2][2];
  logic [7:0] q_wdata [2][2];
  bit         gen_en;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] ack;
    logic [1:0] hold;
    logic [7:0] rd_c;
    logic [7:0] rd_d;
    logic       re;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } obs_t;

  function automatic int mb(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.gnt = {if0.dma_gnt, if0.cpu_gnt};   o.ack = {if0.dma_ack, if0.cpu_ack};
      o.hold = {if0.dma_hold, if0.cpu_hold}; o.rd_c = if0.cpu_rdata; o.rd_d = if0.dma_rdata;
      o.re = if0.mem_re; o.we = if0.mem_we; o.addr = if0.mem_addr; o.wdata = if0.mem_wdata;
    end else begin
      o.gnt = {if1.dma_gnt, if1.cpu_gnt};   o.ack = {if1.dma_ack, if1.cpu_ack};
      o.hold = {if1.dma_hold, if1.cpu_hold}; o.rd_c = if1.cpu_rdata; o.rd_d = if1.dma_rdata;
      o.re = if1.mem_re; o.we = if1.mem_we; o.addr = if1.mem_addr; o.wdata = if1.mem_wdata;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    obs_t o;
    logic eg, ea, eh;
    logic [7:0] er;
    o = get_obs(d);
    for (int s = 0; s < 2; s++) begin
      eg = (m_phase[d] != 0) && (m_owner[d] == s);
      ea = (m_phase[d] == 2) && (m_owner[d] == s);
      er = (ea && m_we[d] == 0) ? 8'(m_mem[d][m_addr[d]]) : 8'h00;
      eh = rst_n && q_req[d][s] && !eg;
      m_last_ack[d][s] = ea;
      chk($sformatf("d%0d s%0d gnt", d, s), 32'(o.gnt[s]), 32'(eg));
      chk($sformatf("d%0d s%0d ack", d, s), 32'(o.ack[s]), 32'(ea));
      chk($sformatf("d%0d s%0d hold", d, s), 32'(o.hold[s]), 32'(eh));
      chk($sformatf("d%0d s%0d rdata", d, s), 32'((s == 0) ? o.rd_c : o.rd_d), 32'(er));
    end
    chk($sformatf("d%0d mem_re", d), 32'(o.re), 32'(m_phase[d] == 1 && m_we[d] == 0));
    chk($sformatf("d%0d mem_we", d), 32'(o.we), 32'(m_phase[d] == 1 && m_we[d] == 1));
    if (m_phase[d] == 1) begin
      chk($sformatf("d%0d mem_addr", d), 32'(o.addr), 32'(m_addr[d]));
      chk($sformatf("d%0d mem_wdata", d), 32'(o.wdata), 32'(m_wdata[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_owner[d] = 0; m_cnt[d] = 0; m_we[d] = 0;
      m_last_ack[d][0] = 1'b0; m_last_ack[d][1] = 1'b0;
    end
  endtask

  task automatic model_update(input int d);
    int o, x, win;
    case (m_phase[d])
      0: begin
        o = m_owner[d]; x = 1 - o; win = -1;
        if (q_req[d][o] && !q_req[d][x]) begin
          win = o; m_cnt[d] = (m_cnt[d] + 1 > mb(d)) ? mb(d) : m_cnt[d] + 1;
        end else if (!q_req[d][o] && q_req[d][x]) begin
          win = x; m_cnt[d] = 1;
        end else if (q_req[d][o] && q_req[d][x]) begin
          if (m_cnt[d] < mb(d)) begin win = o; m_cnt[d] = m_cnt[d] + 1; end
          else begin win = x; m_cnt[d] = 1; end
        end
        if (win >= 0) begin
          m_owner[d] = win; m_we[d] = int'(q_we[d][win]);
          m_addr[d] = int'(q_addr[d][win]); m_wdata[d] = int'(q_wdata[d][win]);
          m_phase[d] = 1;
        end
      end
      1: begin
        if (m_we[d] == 1) m_mem[d][m_addr[d]] = m_wdata[d];
        m_phase[d] = 2;
      end
      default: m_phase[d] = 0;
    endcase
  endtask

  task automatic drive();
    if0.cpu_req = q_req[0][0]; if0.cpu_we = q_we[0][0]; if0.cpu_addr = q_addr[0][0]; if0.cpu_wdata = q_wdata[0][0];
    if0.dma_req = q_req[0][1]; if0.dma_we = q_we[0][1]; if0.dma_addr = q_addr[0][1]; if0.dma_wdata = q_wdata[0][1];
    if1.cpu_req = q_req[1][0]; if1.cpu_we = q_we[1][0]; if1.cpu_addr = q_addr[1][0]; if1.cpu_wdata = q_wdata[1][0];
    if1.dma_req = q_req[1][1]; if1.dma_we = q_we[1][1]; if1.dma_addr = q_addr[1][1]; if1.dma_wdata = q_wdata[1][1];
  endtask

  task automatic set_both(input int s, input bit r, input bit we, input logic [4:0] a, input logic [7:0] w);
    for (int d = 0; d < 2; d++) begin
      q_req[d][s] = r; q_we[d][s] = we; q_addr[d][s] = a; q_wdata[d][s] = w;
    end
  endtask

  // Random requesters keep a command stable until it is acknowledged.
  task automatic gen();
    if (gen_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 2; s++) begin
          if (!q_req[d][s] || m_last_ack[d][s]) begin
            q_req[d][s]   = ($urandom_range(0, 99) < 60);
            q_we[d][s]    = 1'($urandom_range(0, 1));
            q_addr[d][s]  = 5'($urandom_range(0, 7));
            q_wdata[d][s] = 8'($urandom_range(0, 255));
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_update(0);
      model_update(1);
    end
    @(negedge clk);
    gen();
  endtask

  task automatic sample_check();
    check_dut(0);
    check_dut(1);
  endtask

  task automatic cycle();
    drive();
    #1;
    sample_check();
    step();
  endtask

  int         nwe;
  int         n0, n1, last1;
  logic [11:0] seq0, seq1;

  initial begin
    rst_n = 1'b0; gen_en = 1'b0; init_en = 1'b0; init_addr = '0; init_data = '0;
    for (int d = 0; d < 2; d++) for (int s = 0; s < 2; s++) begin
      q_req[d][s] = 1'b0; q_we[d][s] = 1'b0; q_addr[d][s] = '0; q_wdata[d][s] = '0;
    end
    model_reset();
    drive();
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      init_addr = 5'(i);
      init_data = (i == 10) ? 8'h3C : 8'(i * 7 + 3);
      init_en   = 1'b1;
      m_mem[0][i] = int'(init_data); m_mem[1][i] = int'(init_data);
      @(posedge clk);
      @(negedge clk);
    end
    init_en = 1'b0;
    drive(); #1; sample_check();

    // Reset in the middle of a write issue
    set_both(0, 1'b1, 1'b1, 5'h03, 8'h77);
    rst_n = 1'b1;
    cycle();
    drive(); #1; sample_check();
    rst_n = 1'b0; #1;
    model_reset();
    chk("t1 mem_we in reset", 32'(if0.mem_we), 32'd0);
    chk("t1 cpu_gnt in reset", 32'(if0.cpu_gnt), 32'd0);
    set_both(0, 1'b0, 1'b0, 5'h00, 8'h00);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle();
    chk("t1 abandoned write", 32'(pmem0[3]), 32'd24);

    // CPU read of a preloaded word
    set_both(0, 1'b1, 1'b0, 5'h0A, 8'h00);
    cycle(); cycle();
    drive(); #1;
    chk("t2 cpu_rdata", 32'(if0.cpu_rdata), 32'h3C);
    chk("t2 dma_gnt idle", 32'(if0.dma_gnt), 32'd0);
    sample_check(); step();
    set_both(0, 1'b0, 1'b0, 5'h00, 8'h00);

    // DMA write followed by CPU read-back
    nwe = 0;
    set_both(1, 1'b1, 1'b1, 5'h1F, 8'hA5);
    repeat (3) begin drive(); #1; nwe += int'(if0.mem_we); sample_check(); step(); end
    set_both(1, 1'b0, 1'b0, 5'h00, 8'h00);
    set_both(0, 1'b1, 1'b0, 5'h1F, 8'h00);
    repeat (2) begin drive(); #1; nwe += int'(if0.mem_we); sample_check(); step(); end
    drive(); #1;
    chk("t3 cpu_rdata", 32'(if0.cpu_rdata), 32'hA5);
    nwe += int'(if0.mem_we);
    sample_check(); step();
    chk("t3 mem_we pulses", 32'(nwe), 32'd1);
    set_both(0, 1'b0, 1'b0, 5'h00, 8'h00);

    // Both requesting from reset: bursts of four on DUT0, strict alternation on DUT1
    rst_n = 1'b0; #1; model_reset();
    set_both(0, 1'b1, 1'b0, 5'h01, 8'h00);
    set_both(1, 1'b1, 1'b1, 5'h02, 8'h11);
    drive(); #1; sample_check();
    @(negedge clk);
    rst_n = 1'b1;
    n0 = 0; n1 = 0; last1 = -1; seq0 = '0; seq1 = '0;
    for (int k = 0; k < 36; k++) begin
      drive(); #1;
      if (k == 1) chk("t5 first grant cpu", 32'(if0.cpu_gnt), 32'd1);
      if (if0.cpu_ack || if0.dma_ack) begin seq0 = {seq0[10:0], if0.dma_ack}; n0++; end
      if (if1.cpu_ack || if1.dma_ack) begin
        seq1 = {seq1[10:0], if1.dma_ack}; n1++;
        if (last1 >= 0) chk("t6 ack spacing", 32'(k - last1), 32'd3);
        last1 = k;
      end
      sample_check(); step();
    end
    chk("t4 burst order", 32'(seq0), 32'(12'b0000_1111_0000));
    chk("t6 alternation", 32'(seq1), 32'(12'b0101_0101_0101));
    chk("t4 transfers", 32'(n0), 32'd12);
    chk("t6 transfers", 32'(n1), 32'd12);

    // CPU burst then DMA alone: granted straight out of the next arbitration cycle
    rst_n = 1'b0; #1; model_reset();
    set_both(1, 1'b0, 1'b0, 5'h00, 8'h00);
    set_both(0, 1'b1, 1'b0, 5'h04, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(); cycle(); cycle();
    set_both(0, 1'b0, 1'b0, 5'h00, 8'h00);
    set_both(1, 1'b1, 1'b0, 5'h05, 8'h00);
    cycle();
    drive(); #1;
    chk("t5 dma no idle", 32'(if0.dma_gnt), 32'd1);
    sample_check(); step();
    cycle();
    set_both(1, 1'b0, 1'b0, 5'h00, 8'h00);

    // Random traffic on both instances
    gen_en = 1'b1;
    repeat (400) cycle();
    gen_en = 1'b0;
    for (int d = 0; d < 2; d++) for (int s = 0; s < 2; s++) q_req[d][s] = 1'b0;
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
